la_uart_readout: RTL

Readout engine for the capture side of the logic analyzer. It waits for the analyzer's `done`, sweeps `read_addr` across the whole capture window, and serializes every `DATA_WIDTH`-bit sample as bytes over an 8N1 UART to the host. When the sweep is finished it pulses the analyzer's re-arm input. It sits between the analyzer core and the FPGA's UART TX pin.

---
 rtl/la_uart_readout_if.sv | 30 +++
 rtl/la_uart_readout.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/la_uart_readout_if.sv
// la_uart_readout_if: analyzer-side bus between the capture core and the
// readout engine.
//   done      : capture-complete flag from the analyzer
//   read_addr : sample offset presented to the analyzer
//   read_data : registered sample returned by the analyzer
//   la_rearm  : one-cycle restart pulse back to the analyzer
// Modports: master = readout engine, slave = analyzer core.
interface la_uart_readout_if #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 9
);
  logic                  done;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  la_rearm;

  modport master (
    input  done,
    input  read_data,
    output read_addr,
    output la_rearm
  );

  modport slave (
    output done,
    output read_data,
    input  read_addr,
    input  la_rearm
  );
endinterface

// File: rtl/la_uart_readout.sv
// la_uart_readout: after the analyzer reports done, sweeps read_addr over
// the capture window and sends every sample little-endian as 8N1 UART
// bytes, then pulses la_rearm and waits for done to clear.
// Ports:
//   clk      : system clock (same as the analyzer)
//   reset_n  : asynchronous active-low reset
//   la       : analyzer bus (done, read_addr, read_data, la_rearm)
//   uart_tx  : serial output, idle high
//   busy     : high from dump start until re-arm is complete
// Optional feature: define LA_READOUT_HEADER_EN to prefix each dump with
// the header bytes A5 5A DEPTH[7:0] DEPTH[15:8].
module la_uart_readout #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned BAUD_DIV   = 868
) (
  input  logic              clk,
  input  logic              reset_n,
  la_uart_readout_if.master la,
  output logic              uart_tx,
  output logic              busy
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned BAUD_W = $clog2(BAUD_DIV);
  localparam int unsigned BYTE_W = ($clog2(NBYTES) > 2) ? $clog2(NBYTES) : 2;
  localparam int unsigned BIT_W  = 4;
`ifdef LA_READOUT_HEADER_EN
  localparam int unsigned HDR_BYTES = 4;
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_LOAD,
    S_TXB,
    S_NEXT,
    S_REARM,
    S_WAIT_CLR
`ifdef LA_READOUT_HEADER_EN
    , S_HDR
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [BYTE_W-1:0]     byte_idx_q, byte_idx_d;
  logic [BAUD_W-1:0]     baud_q, baud_d, baud_nxt;
  logic [BIT_W-1:0]      bit_q, bit_d, bit_nxt;
  logic                  wait_q, wait_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
  logic                  la_rearm_q, la_rearm_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  baud_end, frame_end, in_frame;
  logic [7:0]            cur_byte;
`ifdef LA_READOUT_HEADER_EN
  logic [31:0]           hdr_q, hdr_d;
`endif

  // Bit-period and frame-position tick shared by every transmitting state.
  always_comb begin
    baud_end  = (baud_q == BAUD_W'(BAUD_DIV - 1));
    frame_end = baud_end && (bit_q == BIT_W'(9));
    baud_nxt  = baud_end ? '0 : baud_q + BAUD_W'(1);
    bit_nxt   = frame_end ? '0 : (baud_end ? bit_q + BIT_W'(1) : bit_q);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    wait_d      = wait_q;
    word_d      = word_q;
    read_addr_d = read_addr_q;
    la_rearm_d  = 1'b0;
`ifdef LA_READOUT_HEADER_EN
    hdr_d       = hdr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (la.done) begin
          word_idx_d = '0;
          byte_idx_d = '0;
          baud_d     = '0;
          bit_d      = '0;
`ifdef LA_READOUT_HEADER_EN
          hdr_d      = {16'(DEPTH), 8'h5A, 8'hA5};
          state_d    = S_HDR;
`else
          state_d    = S_ADDR;
`endif
        end
      end
`ifdef LA_READOUT_HEADER_EN
      S_HDR: begin
        baud_d = baud_nxt;
        bit_d  = bit_nxt;
        if (frame_end) begin
          if (byte_idx_q < BYTE_W'(HDR_BYTES - 1)) begin
            byte_idx_d = byte_idx_q + BYTE_W'(1);
            hdr_d      = hdr_q >> 8;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
`endif
      S_ADDR: begin
        read_addr_d = word_idx_q;
        wait_d      = 1'b0;
        state_d     = S_WAIT;
      end
      // Two cycles cover the analyzer's registered read.
      S_WAIT: begin
        if (wait_q) state_d = S_LOAD;
        else        wait_d  = 1'b1;
      end
      S_LOAD: begin
        word_d     = la.read_data;
        byte_idx_d = '0;
        baud_d     = '0;
        bit_d      = '0;
        state_d    = S_TXB;
      end
      // The shift word moves down a byte per frame so byte 0 leaves first.
      S_TXB: begin
        baud_d = baud_nxt;
        bit_d  = bit_nxt;
        if (frame_end) begin
          if (byte_idx_q < BYTE_W'(NBYTES - 1)) begin
            byte_idx_d = byte_idx_q + BYTE_W'(1);
            word_d     = word_q >> 8;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (word_idx_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d    = S_REARM;
          la_rearm_d = 1'b1;
        end else begin
          word_idx_d = word_idx_q + ADDR_WIDTH'(1);
          state_d    = S_ADDR;
        end
      end
      S_REARM: begin
        state_d = S_WAIT_CLR;
      end
      // Holding here until done drops prevents dumping the same capture twice.
      S_WAIT_CLR: begin
        if (!la.done) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);

    // Line level for the coming cycle, derived from the next frame position.
    in_frame = (state_d == S_TXB);
    cur_byte = word_d[7:0];
`ifdef LA_READOUT_HEADER_EN
    if (state_d == S_HDR) begin
      in_frame = 1'b1;
      cur_byte = hdr_d[7:0];
    end
`endif
    tx_d = 1'b1;
    if (in_frame) begin
      if (bit_d == BIT_W'(0))      tx_d = 1'b0;
      else if (bit_d == BIT_W'(9)) tx_d = 1'b1;
      else                         tx_d = cur_byte[3'(bit_d - BIT_W'(1))];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      baud_q      <= '0;
      bit_q       <= '0;
      wait_q      <= 1'b0;
      word_q      <= '0;
      read_addr_q <= '0;
      la_rearm_q  <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
`ifdef LA_READOUT_HEADER_EN
      hdr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      wait_q      <= wait_d;
      word_q      <= word_d;
      read_addr_q <= read_addr_d;
      la_rearm_q  <= la_rearm_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
`ifdef LA_READOUT_HEADER_EN
      hdr_q       <= hdr_d;
`endif
    end
  end

  assign la.read_addr = read_addr_q;
  assign la.la_rearm  = la_rearm_q;
  assign uart_tx      = tx_q;
  assign busy         = busy_q;

endmodule
